// File: rtl/param_reg_file_pkg.sv
// rtl/param_reg_file_pkg.sv - shared register-file definitions
package param_reg_file_pkg;
    localparam int WORD         = 32;
    localparam int PC_REG_NUM   = 15;
    localparam int SP_REG_NUM   = 13;
    localparam int WR_PORT_ALU  = 0;
    localparam int WR_PORT_LOAD = 1;

    typedef logic [3:0] reg_addr_t;
endpackage

// File: rtl/param_reg_file_if.sv
// rtl/param_reg_file_if.sv - read, write and issue bundle of the register file
interface param_reg_file_if
    import param_reg_file_pkg::*;
#(
    parameter int WIDTH    = WORD,
    parameter int NUM_REGS = 16,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2
);
    localparam int AW = $clog2(NUM_REGS);

    logic [NUM_RD-1:0][AW-1:0]    rd_addr_i;
    logic [NUM_RD-1:0][WIDTH-1:0] rd_data_o;
    logic [NUM_RD-1:0]            rd_pending_o;
    logic [NUM_WR-1:0]            wr_en_i;
    logic [NUM_WR-1:0][AW-1:0]    wr_addr_i;
    logic [NUM_WR-1:0][WIDTH-1:0] wr_data_i;
    logic                         issue_en_i;
    logic [AW-1:0]                issue_addr_i;

    modport master (
        output rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, issue_en_i, issue_addr_i,
        input  rd_data_o, rd_pending_o
    );

    modport slave (
        input  rd_addr_i, wr_en_i, wr_addr_i, wr_data_i, issue_en_i, issue_addr_i,
        output rd_data_o, rd_pending_o
    );
endinterface

// File: rtl/param_reg_file_reg_scoreboard.sv
// rtl/param_reg_file_reg_scoreboard.sv - pending-write scoreboard with per-read-port lookahead
module reg_scoreboard
    import param_reg_file_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int NUM_WR   = 2,
    parameter int NUM_RD   = 2,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_WR-1:0]         wr_en_i,
    input  logic [NUM_WR-1:0][AW-1:0] wr_addr_i,
    input  logic                      issue_en_i,
    input  logic [AW-1:0]             issue_addr_i,
    input  logic [NUM_RD-1:0][AW-1:0] rd_addr_i,
    output logic [NUM_REGS-1:0]       pending_o,
    output logic [NUM_RD-1:0]         rd_pending_d_o
);
    localparam logic [AW-1:0] PC_ADDR = AW'(PC_REG_NUM);

    logic [NUM_REGS-1:0] pending_q;
    logic [NUM_REGS-1:0] pending_d;

    // Issue is applied after the clears: the newly issued producer is younger.
    always_comb begin
        pending_d = pending_q;
        for (int p = 0; p < NUM_WR; p++) begin
            if (wr_en_i[p]) begin
                pending_d[wr_addr_i[p]] = 1'b0;
            end
        end
        if (issue_en_i && (issue_addr_i != PC_ADDR)) begin
            pending_d[issue_addr_i] = 1'b1;
        end
        pending_d[PC_ADDR] = 1'b0;
    end

    always_comb begin
        rd_pending_d_o = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            rd_pending_d_o[r] = pending_d[rd_addr_i[r]];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;
endmodule

// File: rtl/param_reg_file.sv
// rtl/param_reg_file.sv - multi-port register file with bypassed registered reads and PC path
module param_reg_file
    import param_reg_file_pkg::*;
#(
    parameter int WIDTH    = WORD,
    parameter int NUM_REGS = 16,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    param_reg_file_if.slave     bus,
    input  logic [WIDTH-1:0]    pc_i,
    output logic [WIDTH-1:0]    pc_o,
    output logic [WIDTH-1:0]    sp_o,
    output logic [NUM_REGS-1:0] pending_o
);
    localparam logic [AW-1:0] PC_ADDR = AW'(PC_REG_NUM);
    localparam logic [AW-1:0] SP_ADDR = AW'(SP_REG_NUM);

    logic [WIDTH-1:0]             regs_q [NUM_REGS];
    logic [WIDTH-1:0]             regs_d [NUM_REGS];
    logic [NUM_RD-1:0][WIDTH-1:0] rd_data_q;
    logic [NUM_RD-1:0][WIDTH-1:0] rd_data_d;
    logic [NUM_RD-1:0]            rd_pending_q;
    logic [NUM_RD-1:0]            rd_pending_d;

    // Later ports overwrite earlier ones; PC is owned by pc_i alone.
    always_comb begin
        regs_d = regs_q;
        for (int p = 0; p < NUM_WR; p++) begin
            if (bus.wr_en_i[p] && (bus.wr_addr_i[p] != PC_ADDR)) begin
                regs_d[bus.wr_addr_i[p]] = bus.wr_data_i[p];
            end
        end
        regs_d[PC_ADDR] = pc_i;
    end

    always_comb begin
        rd_data_d = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            rd_data_d[r] = regs_d[bus.rd_addr_i[r]];
        end
    end

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_WR   (NUM_WR),
        .NUM_RD   (NUM_RD)
    ) u_scoreboard (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .wr_en_i        (bus.wr_en_i),
        .wr_addr_i      (bus.wr_addr_i),
        .issue_en_i     (bus.issue_en_i),
        .issue_addr_i   (bus.issue_addr_i),
        .rd_addr_i      (bus.rd_addr_i),
        .pending_o      (pending_o),
        .rd_pending_d_o (rd_pending_d)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            rd_data_q    <= '0;
            rd_pending_q <= '0;
        end else begin
            regs_q       <= regs_d;
            rd_data_q    <= rd_data_d;
            rd_pending_q <= rd_pending_d;
        end
    end

    assign bus.rd_data_o    = rd_data_q;
    assign bus.rd_pending_o = rd_pending_q;
    assign pc_o             = regs_q[PC_ADDR];
    assign sp_o             = regs_q[SP_ADDR];
endmodule

// File: tb/tb_param_reg_file.sv
// tb/tb_param_reg_file.sv - directed table plus randomized model comparison for param_reg_file
module tb_param_reg_file;
    import param_reg_file_pkg::*;

    localparam int W   = 32;
    localparam int NR  = 16;
    localparam int NRD = 2;
    localparam int NWR = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  pc_in;
    logic [W-1:0]  pc_out;
    logic [W-1:0]  sp_out;
    logic [NR-1:0] pend_out;

    always #5 clk = ~clk;

    param_reg_file_if #(.WIDTH(W), .NUM_REGS(NR), .NUM_RD(NRD), .NUM_WR(NWR)) bus ();

    param_reg_file #(.WIDTH(W), .NUM_REGS(NR), .NUM_RD(NRD), .NUM_WR(NWR)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .bus       (bus),
        .pc_i      (pc_in),
        .pc_o      (pc_out),
        .sp_o      (sp_out),
        .pending_o (pend_out)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  we;
        reg_addr_t   wa0;
        logic [31:0] wd0;
        reg_addr_t   wa1;
        logic [31:0] wd1;
        logic        iss;
        reg_addr_t   ia;
        logic [31:0] pc;
        reg_addr_t   ra0;
        reg_addr_t   ra1;
        logic [31:0] e_rd0;
        logic [31:0] e_rd1;
        logic [1:0]  e_rp;
        logic [31:0] e_pc;
        logic [31:0] e_sp;
        logic [15:0] e_pend;
    } vec_t;

    vec_t vecs[13];

    int vec_count  = 0;
    int miss_count = 0;

    logic [31:0] m_regs [NR];
    logic [15:0] m_pend;
    logic [31:0] m_rd   [NRD];
    logic        m_rp   [NRD];

    function automatic vec_t mk(logic r, logic [1:0] we, reg_addr_t wa0, logic [31:0] wd0,
                                reg_addr_t wa1, logic [31:0] wd1, logic iss, reg_addr_t ia,
                                logic [31:0] pc, reg_addr_t ra0, reg_addr_t ra1,
                                logic [31:0] e_rd0, logic [31:0] e_rd1, logic [1:0] e_rp,
                                logic [31:0] e_pc, logic [31:0] e_sp, logic [15:0] e_pend);
        vec_t v;
        v.rst = r; v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
        v.iss = iss; v.ia = ia; v.pc = pc; v.ra0 = ra0; v.ra1 = ra1;
        v.e_rd0 = e_rd0; v.e_rd1 = e_rd1; v.e_rp = e_rp;
        v.e_pc = e_pc; v.e_sp = e_sp; v.e_pend = e_pend;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            miss_count++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: each register takes the value of the highest port aiming at it,
    // the pending bit is decided per register from "issued here" / "written here".
    task automatic model_step();
        logic [31:0] nxt [NR];
        logic [15:0] pnd;
        bit          hit;
        bit          wrote;
        if (rst) begin
            for (int i = 0; i < NR; i++) m_regs[i] = '0;
            m_pend = '0;
            for (int r = 0; r < NRD; r++) begin
                m_rd[r] = '0;
                m_rp[r] = 1'b0;
            end
            return;
        end
        for (int i = 0; i < NR; i++) begin
            nxt[i] = m_regs[i];
            hit    = 1'b0;
            wrote  = 1'b0;
            for (int p = NWR - 1; p >= 0; p--) begin
                if (bus.wr_en_i[p] && int'(bus.wr_addr_i[p]) == i) begin
                    wrote = 1'b1;
                    if (!hit) begin
                        nxt[i] = bus.wr_data_i[p];
                        hit    = 1'b1;
                    end
                end
            end
            if (i == PC_REG_NUM) begin
                nxt[i] = pc_in;
                pnd[i] = 1'b0;
            end else if (bus.issue_en_i && int'(bus.issue_addr_i) == i) begin
                pnd[i] = 1'b1;
            end else if (wrote) begin
                pnd[i] = 1'b0;
            end else begin
                pnd[i] = m_pend[i];
            end
        end
        for (int i = 0; i < NR; i++) m_regs[i] = nxt[i];
        m_pend = pnd;
        for (int r = 0; r < NRD; r++) begin
            m_rd[r] = m_regs[bus.rd_addr_i[r]];
            m_rp[r] = m_pend[bus.rd_addr_i[r]];
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(vec_t v);
        rst                 = v.rst;
        bus.wr_en_i         = v.we;
        bus.wr_addr_i[WR_PORT_ALU]  = v.wa0;
        bus.wr_data_i[WR_PORT_ALU]  = v.wd0;
        bus.wr_addr_i[WR_PORT_LOAD] = v.wa1;
        bus.wr_data_i[WR_PORT_LOAD] = v.wd1;
        bus.issue_en_i      = v.iss;
        bus.issue_addr_i    = v.ia;
        pc_in               = v.pc;
        bus.rd_addr_i[0]    = v.ra0;
        bus.rd_addr_i[1]    = v.ra1;
    endtask

    initial begin
        vecs[0]  = mk(1, 2'b00, 0, 0, 0, 0, 0, 0, 32'h50,  3, 13, 0, 0, 2'b00, 0, 0, 16'h0);
        vecs[1]  = mk(1, 2'b00, 0, 0, 0, 0, 0, 0, 32'h50,  3, 13, 0, 0, 2'b00, 0, 0, 16'h0);
        vecs[2]  = mk(0, 2'b01, 4, 32'hDEADBEEF, 0, 0, 0, 0, 32'h100, 4, 13,
                      32'hDEADBEEF, 0, 2'b00, 32'h100, 0, 16'h0);
        vecs[3]  = mk(0, 2'b11, 2, 32'h11, 2, 32'h22, 0, 0, 32'h104, 4, 2,
                      32'hDEADBEEF, 32'h22, 2'b00, 32'h104, 0, 16'h0);
        vecs[4]  = mk(0, 2'b01, 15, 32'h1234, 0, 0, 0, 0, 32'h100, 15, 2,
                      32'h100, 32'h22, 2'b00, 32'h100, 0, 16'h0);
        vecs[5]  = mk(0, 2'b10, 0, 0, 13, 32'hCAFE, 0, 0, 32'h108, 13, 15,
                      32'hCAFE, 32'h108, 2'b00, 32'h108, 32'hCAFE, 16'h0);
        vecs[6]  = mk(0, 2'b00, 0, 0, 0, 0, 1, 5, 32'h10C, 5, 4,
                      0, 32'hDEADBEEF, 2'b01, 32'h10C, 32'hCAFE, 16'h0020);
        vecs[7]  = mk(0, 2'b10, 0, 0, 5, 32'h77, 1, 5, 32'h110, 5, 5,
                      32'h77, 32'h77, 2'b11, 32'h110, 32'hCAFE, 16'h0020);
        vecs[8]  = mk(0, 2'b01, 5, 32'h88, 0, 0, 0, 0, 32'h114, 5, 2,
                      32'h88, 32'h22, 2'b00, 32'h114, 32'hCAFE, 16'h0);
        vecs[9]  = mk(0, 2'b00, 0, 0, 0, 0, 1, 15, 32'h118, 15, 5,
                      32'h118, 32'h88, 2'b00, 32'h118, 32'hCAFE, 16'h0);
        vecs[10] = mk(0, 2'b01, 7, 32'h3, 0, 0, 1, 7, 32'h11C, 7, 3,
                      32'h3, 0, 2'b01, 32'h11C, 32'hCAFE, 16'h0080);
        vecs[11] = mk(1, 2'b01, 7, 32'h9, 0, 0, 1, 7, 32'h120, 7, 4,
                      0, 0, 2'b00, 0, 0, 16'h0);
        vecs[12] = mk(0, 2'b00, 0, 0, 0, 0, 0, 0, 32'h200, 7, 4,
                      0, 0, 2'b00, 32'h200, 0, 16'h0);

        apply(vecs[0]);
        for (int i = 0; i < 13; i++) begin
            apply(vecs[i]);
            tick();
            chk($sformatf("v%0d.rd0", i),  bus.rd_data_o[0],       vecs[i].e_rd0);
            chk($sformatf("v%0d.rd1", i),  bus.rd_data_o[1],       vecs[i].e_rd1);
            chk($sformatf("v%0d.rp", i),   32'(bus.rd_pending_o),  32'(vecs[i].e_rp));
            chk($sformatf("v%0d.pc", i),   pc_out,                 vecs[i].e_pc);
            chk($sformatf("v%0d.sp", i),   sp_out,                 vecs[i].e_sp);
            chk($sformatf("v%0d.pend", i), 32'(pend_out),          32'(vecs[i].e_pend));
        end

        for (int n = 0; n < 400; n++) begin
            rst              = ($urandom_range(0, 49) == 0);
            bus.wr_en_i      = 2'($urandom_range(0, 3));
            bus.wr_addr_i[0] = 4'($urandom_range(0, 15));
            bus.wr_addr_i[1] = ($urandom_range(0, 3) == 0) ? bus.wr_addr_i[0]
                                                           : 4'($urandom_range(0, 15));
            bus.wr_data_i[0] = $urandom;
            bus.wr_data_i[1] = $urandom;
            bus.issue_en_i   = ($urandom_range(0, 2) == 0);
            bus.issue_addr_i = 4'($urandom_range(0, 15));
            pc_in            = $urandom;
            bus.rd_addr_i[0] = ($urandom_range(0, 2) == 0) ? bus.wr_addr_i[1]
                                                           : 4'($urandom_range(0, 15));
            bus.rd_addr_i[1] = ($urandom_range(0, 3) == 0) ? bus.rd_addr_i[0]
                                                           : 4'($urandom_range(0, 15));
            tick();
            chk($sformatf("r%0d.rd0", n),  bus.rd_data_o[0],          m_rd[0]);
            chk($sformatf("r%0d.rd1", n),  bus.rd_data_o[1],          m_rd[1]);
            chk($sformatf("r%0d.rp0", n),  32'(bus.rd_pending_o[0]),  32'(m_rp[0]));
            chk($sformatf("r%0d.rp1", n),  32'(bus.rd_pending_o[1]),  32'(m_rp[1]));
            chk($sformatf("r%0d.pc", n),   pc_out,                    m_regs[PC_REG_NUM]);
            chk($sformatf("r%0d.sp", n),   sp_out,                    m_regs[SP_REG_NUM]);
            chk($sformatf("r%0d.pend", n), 32'(pend_out),             32'(m_pend));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end
endmodule
